// File: rtl/seg_watch.sv
// seg_watch: snoops register-file writes to one watched register and shows
// each captured 32-bit word on a single active-low 7-segment digit as eight
// hex nibbles (MSB first) followed by a dash. Holds one pending word so that
// back-to-back writes never stall the core; the latest pending word wins.
module seg_watch #(
    parameter int unsigned DWELL     = 25_000_000,
    parameter logic [4:0]  WATCH_REG = 5'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  wr_reg,
    input  logic [31:0] wr_data,
    output logic [6:0]  seg,
    output logic        busy,
    output logic        drop
);

    localparam int unsigned       CNT_W    = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [6:0]        SEG_BLANK = 7'h7F;
    localparam logic [6:0]        SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [31:0]      word, word_d;
    logic [2:0]       idx, idx_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [31:0]      pend_word, pend_word_d;
    logic             pend_valid, pend_valid_d;
    logic [6:0]       seg_d;
    logic             busy_d;
    logic             drop_d;
    logic             hit_c;
    logic             dwell_done_c;
    logic [3:0]       nib_c;

    // Hex digit to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Write-port snoop; $zero is never treated as a hit.
    assign hit_c        = wr_en && (wr_reg == WATCH_REG) && (wr_reg != 5'd0);
    assign dwell_done_c = (cnt == CNT_LAST);

    // Next-state, pending capture and next display value.
    always_comb begin
        state_d      = state;
        word_d       = word;
        idx_d        = idx;
        cnt_d        = cnt;
        pend_word_d  = pend_word;
        pend_valid_d = pend_valid;
        drop_d       = 1'b0;

        case (state)
            S_IDLE: begin
                if (hit_c) begin
                    state_d = S_SHOW;
                    word_d  = wr_data;
                    idx_d   = 3'd7;
                    cnt_d   = '0;
                end
            end
            S_SHOW: begin
                if (dwell_done_c) begin
                    cnt_d = '0;
                    if (idx == 3'd0) begin
                        state_d = S_GAP;
                    end else begin
                        idx_d = idx - 3'd1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
                if (hit_c) begin
                    pend_word_d  = wr_data;
                    pend_valid_d = 1'b1;
                    drop_d       = pend_valid;
                end
            end
            S_GAP: begin
                if (dwell_done_c) begin
                    cnt_d = '0;
                    if (hit_c) begin
                        // A fresh write at the gap edge beats the older pending word.
                        state_d      = S_SHOW;
                        word_d       = wr_data;
                        idx_d        = 3'd7;
                        pend_valid_d = 1'b0;
                        drop_d       = pend_valid;
                    end else if (pend_valid) begin
                        state_d      = S_SHOW;
                        word_d       = pend_word;
                        idx_d        = 3'd7;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                    if (hit_c) begin
                        pend_word_d  = wr_data;
                        pend_valid_d = 1'b1;
                        drop_d       = pend_valid;
                    end
                end
            end
            default: begin
                state_d      = S_IDLE;
                cnt_d        = '0;
                pend_valid_d = 1'b0;
            end
        endcase

        nib_c  = 4'(word_d >> {idx_d, 2'b00});
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_SHOW:  seg_d = hex_to_seg(nib_c);
            S_GAP:   seg_d = SEG_DASH;
            default: seg_d = SEG_BLANK;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            word       <= '0;
            idx        <= '0;
            cnt        <= '0;
            pend_word  <= '0;
            pend_valid <= 1'b0;
            seg        <= SEG_BLANK;
            busy       <= 1'b0;
            drop       <= 1'b0;
        end else begin
            state      <= state_d;
            word       <= word_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            pend_word  <= pend_word_d;
            pend_valid <= pend_valid_d;
            seg        <= seg_d;
            busy       <= busy_d;
            drop       <= drop_d;
        end
    end

endmodule

// File: tb/tb_seg_watch.sv
// Testbench for seg_watch: table-driven vectors for reset, a single word and
// write filtering, plus hand-written sequences for pending overwrite, the
// gap-edge collision and reset in the middle of a word.
module tb_seg_watch;

    localparam int unsigned DWELL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [6:0]  seg_a, seg_b;
    logic        busy_a, busy_b;
    logic        drop_a, drop_b;

    int tests = 0;
    int fails = 0;
    int drop_seen = 0;

    logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic        rst;
        logic        wr_en;
        logic [4:0]  wr_reg;
        logic [31:0] wr_data;
        logic [6:0]  seg;
        logic        busy;
        logic        drop;
        string       name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    seg_watch #(.DWELL(DWELL), .WATCH_REG(5'd2)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .seg(seg_a), .busy(busy_a), .drop(drop_a)
    );

    // Watches $zero: must never leave IDLE whatever is written.
    seg_watch #(.DWELL(DWELL), .WATCH_REG(5'd0)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .seg(seg_b), .busy(busy_b), .drop(drop_b)
    );

    // Expected segments for output step i (0..15) of word w at DWELL=2.
    function automatic logic [6:0] nib7(input logic [31:0] w, input int i);
        logic [3:0] n;
        n = 4'(w >> (4 * (7 - i / 2)));
        return hex7[n];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic en, input logic [4:0] r, input logic [31:0] d);
        wr_en   = en;
        wr_reg  = r;
        wr_data = d;
    endtask

    task automatic add(input logic r, input logic en, input logic [4:0] rg, input logic [31:0] d,
                       input logic [6:0] s, input logic b, input logic dr, input string nm);
        vec_t v;
        v.rst = r; v.wr_en = en; v.wr_reg = rg; v.wr_data = d;
        v.seg = s; v.busy = b; v.drop = dr; v.name = nm;
        vecs.push_back(v);
    endtask

    // One clock edge, then compare after the outputs settle.
    task automatic step(input string nm, input logic [6:0] es, input logic eb);
        @(posedge clk);
        #1;
        check({nm, " seg"}, 32'(seg_a), 32'(es));
        check({nm, " busy"}, 32'(busy_a), 32'(eb));
        if (drop_a === 1'b1) drop_seen++;
        check({nm, " zero-watch seg"}, 32'(seg_b), 32'h7F);
        check({nm, " zero-watch busy"}, 32'(busy_b), 32'h0);
        check({nm, " zero-watch drop"}, 32'(drop_b), 32'h0);
    endtask

    task automatic show_rest(input string nm, input logic [31:0] w, input int from);
        set_in(1'b0, 5'd0, 32'h0);
        for (int i = from; i < 16; i++) step(nm, nib7(w, i), 1'b1);
    endtask

    task automatic dash(input string nm);
        set_in(1'b0, 5'd0, 32'h0);
        step(nm, 7'h3F, 1'b1);
        step(nm, 7'h3F, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b1, 5'd2, 32'hDEADBEEF);

        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 5'd2, 32'hDEADBEEF, 7'h7F, 1'b0, 1'b0, "reset");
        add(1'b0, 1'b0, 5'd2, 32'h0, 7'h7F, 1'b0, 1'b0, "post_reset");
        add(1'b0, 1'b1, 5'd2, 32'h1234ABCD, 7'h79, 1'b1, 1'b0, "single");
        for (int i = 1; i < 16; i++)
            add(1'b0, 1'b0, 5'd0, 32'h0, nib7(32'h1234ABCD, i), 1'b1, 1'b0, "single");
        add(1'b0, 1'b0, 5'd0, 32'h0, 7'h3F, 1'b1, 1'b0, "single_dash");
        add(1'b0, 1'b0, 5'd0, 32'h0, 7'h3F, 1'b1, 1'b0, "single_dash");
        add(1'b0, 1'b0, 5'd0, 32'h0, 7'h7F, 1'b0, 1'b0, "single_end");
        add(1'b0, 1'b1, 5'd3, 32'hFFFFFFFF, 7'h7F, 1'b0, 1'b0, "filter_reg3");
        add(1'b0, 1'b0, 5'd2, 32'hFFFFFFFF, 7'h7F, 1'b0, 1'b0, "filter_en0");
        add(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 7'h7F, 1'b0, 1'b0, "filter_zero");
        add(1'b0, 1'b1, 5'd0, 32'h12345678, 7'h7F, 1'b0, 1'b0, "filter_zero");
        add(1'b0, 1'b0, 5'd0, 32'h0, 7'h7F, 1'b0, 1'b0, "filter_idle");

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            set_in(vecs[i].wr_en, vecs[i].wr_reg, vecs[i].wr_data);
            step(vecs[i].name, vecs[i].seg, vecs[i].busy);
            check({vecs[i].name, " drop"}, 32'(drop_a), 32'(vecs[i].drop));
        end

        // Pending word overwritten during SHOW: latest wins, one drop.
        drop_seen = 0;
        set_in(1'b1, 5'd2, 32'h00000001);
        step("pend_w1", nib7(32'h00000001, 0), 1'b1);
        set_in(1'b1, 5'd2, 32'hFFFFFFFF);
        step("pend_w1", nib7(32'h00000001, 1), 1'b1);
        set_in(1'b1, 5'd2, 32'h89ABCDEF);
        step("pend_w1", nib7(32'h00000001, 2), 1'b1);
        show_rest("pend_w1", 32'h00000001, 3);
        dash("pend_dash1");
        show_rest("pend_w2", 32'h89ABCDEF, 0);
        dash("pend_dash2");
        step("pend_end", 7'h7F, 1'b0);
        check("pend drop count", 32'(drop_seen), 32'd1);

        // Hit on the final GAP cycle replaces the pending word.
        drop_seen = 0;
        set_in(1'b1, 5'd2, 32'h11111111);
        step("gap_w1", nib7(32'h11111111, 0), 1'b1);
        for (int i = 1; i < 16; i++) begin
            if (i == 4) set_in(1'b1, 5'd2, 32'h22222222);
            else        set_in(1'b0, 5'd0, 32'h0);
            step("gap_w1", nib7(32'h11111111, i), 1'b1);
        end
        set_in(1'b0, 5'd0, 32'h0);
        step("gap_dash", 7'h3F, 1'b1);
        step("gap_dash", 7'h3F, 1'b1);
        set_in(1'b1, 5'd2, 32'h33333333);
        step("gap_w2", 7'h30, 1'b1);
        check("gap edge drop", 32'(drop_a), 32'd1);
        show_rest("gap_w2", 32'h33333333, 1);
        dash("gap_dash2");
        step("gap_end", 7'h7F, 1'b0);
        check("gap drop count", 32'(drop_seen), 32'd1);

        // Reset during nibble 4 with a word pending.
        drop_seen = 0;
        set_in(1'b1, 5'd2, 32'hAAAAAAAA);
        step("rst_mid", nib7(32'hAAAAAAAA, 0), 1'b1);
        set_in(1'b1, 5'd2, 32'h55555555);
        step("rst_mid", nib7(32'hAAAAAAAA, 1), 1'b1);
        set_in(1'b0, 5'd0, 32'h0);
        for (int i = 2; i < 7; i++) step("rst_mid", nib7(32'hAAAAAAAA, i), 1'b1);
        rst = 1'b1;
        step("rst_mid_reset", 7'h7F, 1'b0);
        check("rst_mid drop", 32'(drop_a), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) step("rst_after", 7'h7F, 1'b0);
        check("rst_after drop count", 32'(drop_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
